sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
- Sits between the CPU core's two SRAM-like master ports (instruction and data) and the single SRAM-like slave port of the AXI bridge.
- Merges both masters onto one in-order slave channel.
- Arbitrates address handshakes and tags each accepted transaction with its source in an ID FIFO.
- Routes each returning data_ok back to the master that issued the transaction.

Parameters:
- OUT_DEPTH, 4: maximum outstanding accepted-but-unreturned transactions (ID FIFO depth, power of 2, ≥2).

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
inst_sram_req  in  1  instruction fetch request (read only)
inst_sram_size  in  2  access size
inst_sram_addr  in  32  fetch address
inst_sram_addr_ok  out  1  fetch address accepted
inst_sram_data_ok  out  1  fetch data valid
inst_sram_rdata  out  32  fetch data
data_sram_req  in  1  data request
data_sram_wr  in  1  1 = write
data_sram_size  in  2  access size
data_sram_wstrb  in  4  byte strobes
data_sram_addr  in  32  data address
data_sram_wdata  in  32  write data
data_sram_addr_ok  out  1  data address accepted
data_sram_data_ok  out  1  read data valid / write done
data_sram_rdata  out  32  read data
mem_req  out  1  merged request to bridge
mem_wr  out  1  write flag
mem_size  out  2  size
mem_wstrb  out  4  strobes (4'b0 for instruction requests)
mem_addr  out  32  address
mem_wdata  out  32  write data (32'b0 for instruction requests)
mem_addr_ok  in  1  bridge accepted address
mem_data_ok  in  1  bridge returns one response, strictly in acceptance order
mem_rdata  in  32  response data

Behaviour:
- Reset: clk rising edge with resetn=0 → ID FIFO empty, count=0, lock=0, locked_src=0. All outputs 0 while in reset.
- Grant, combinational each cycle:
  - lock=1: grant=locked_src.
  - lock=0: data wins if data_sram_req=1, else inst if inst_sram_req=1, else none.
- Blocking: no grant is issued when count==OUT_DEPTH, so mem_req=0 when full.
- mem_* mirrors the granted master's fields. mem_req equals the granted master's req.
- addr_ok routing: mem_addr_ok is forwarded combinationally to the granted master only. The other master's addr_ok is 0.
- Lock:
  - If mem_req=1 and mem_addr_ok=0, set lock=1 and locked_src=grant at the edge.
  - Clear lock on the cycle mem_addr_ok=1.
  - Purpose: a request, once presented, is never swapped mid-handshake.
- Accept: mem_req & mem_addr_ok → push grant (0=inst, 1=data) into the ID FIFO, count+1.
- Return: mem_data_ok=1 and count>0 → pop the FIFO head.
  - data_ok is asserted to the head's source only, in the same cycle (zero latency).
  - count−1.
- Simultaneous push and pop: both occur, count unchanged, pointers each advance. Wrap is modulo OUT_DEPTH.
- Full: push is impossible (mem_req gated). A pop in the same cycle does not enable a push that cycle.
- Spurious return: mem_data_ok with count==0 is ignored. No data_ok to either master, and count stays 0 (no underflow).
- rdata: mem_rdata is broadcast to both inst_sram_rdata and data_sram_rdata. Only the data_ok qualifies it.
- Writes: occupy a FIFO slot like reads. Their data_ok goes to data_sram_data_ok.
- Masters are responsible for holding req/fields stable until addr_ok. The arbiter adds no buffering of request fields.
- Mid-operation reset: all outstanding transactions are discarded. Subsequent mem_data_ok with count==0 is ignored.

Test Plan:
- Single fetch: inst req addr=0x1C000000, addr_ok next cycle, data_ok+rdata=0x02800000 two cycles later → exactly one inst_sram_data_ok pulse with rdata 0x02800000. data_sram_data_ok stays 0.
- Contention: both req in the same cycle, bridge addr_ok=1 every cycle → data accepted first (mem_addr=data addr), inst next cycle. Returns in order: data_ok to data, then to inst.
- Lock: inst req alone, mem_addr_ok held 0 for 3 cycles, data req rises in cycle 2 → mem_addr stays the inst address until addr_ok. Data is granted afterwards.
- Full: OUT_DEPTH=4, accept 4 loads with no data_ok → mem_req=0 on the 5th. One data_ok with a simultaneous pending req → push is blocked that cycle and accepted the next cycle.
- Interleaved streams: 8 alternating inst/data with random addr_ok/data_ok delays → every master receives exactly its own responses, in order. count returns to 0.
- Reset: reset with 3 outstanding, then 3 stray mem_data_ok pulses → no master data_ok pulses, count=0, a new fetch completes normally.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// Merges inst/data SRAM-like masters onto one in-order slave; data wins unless a handshake is locked.
// Zero latency: addr_ok and data_ok route combinationally; grants stop while OUT_DEPTH responses are owed.
module sram_like_arbiter #(
  parameter int OUT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  logic                 lock_q, lock_d;
  logic                 locked_src_q, locked_src_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        rptr_q, rptr_d;
  logic [OUT_DEPTH-1:0] id_q, id_d;

  logic full;
  logic grant_vld;
  logic grant_src;
  logic push;
  logic pop;
  logic head_src;

  always_comb begin
    full      = (cnt_q == CW'(OUT_DEPTH));
    grant_vld = 1'b0;
    grant_src = SRC_INST;
    // Reset and a full ID FIFO both suppress any grant.
    if (resetn && !full) begin
      if (lock_q) begin
        grant_vld = 1'b1;
        grant_src = locked_src_q;
      end else if (data_sram_req) begin
        grant_vld = 1'b1;
        grant_src = SRC_DATA;
      end else if (inst_sram_req) begin
        grant_vld = 1'b1;
        grant_src = SRC_INST;
      end
    end

    mem_req   = grant_vld & ((grant_src == SRC_DATA) ? data_sram_req : inst_sram_req);
    mem_wr    = grant_vld & (grant_src == SRC_DATA) & data_sram_wr;
    mem_size  = !grant_vld ? 2'b0 : ((grant_src == SRC_DATA) ? data_sram_size : inst_sram_size);
    mem_wstrb = (grant_vld && grant_src == SRC_DATA) ? data_sram_wstrb : 4'b0;
    mem_addr  = !grant_vld ? 32'b0 : ((grant_src == SRC_DATA) ? data_sram_addr : inst_sram_addr);
    mem_wdata = (grant_vld && grant_src == SRC_DATA) ? data_sram_wdata : 32'b0;

    inst_sram_addr_ok = mem_req & (grant_src == SRC_INST) & mem_addr_ok;
    data_sram_addr_ok = mem_req & (grant_src == SRC_DATA) & mem_addr_ok;

    push     = mem_req & mem_addr_ok;
    pop      = resetn & mem_data_ok & (cnt_q != '0);
    head_src = id_q[rptr_q];

    inst_sram_data_ok = pop & (head_src == SRC_INST);
    data_sram_data_ok = pop & (head_src == SRC_DATA);
    inst_sram_rdata   = resetn ? mem_rdata : 32'b0;
    data_sram_rdata   = resetn ? mem_rdata : 32'b0;
  end

  always_comb begin
    lock_d       = lock_q;
    locked_src_d = locked_src_q;
    // A presented but unaccepted request pins the grant until the bridge takes it.
    if (mem_req) begin
      lock_d       = ~mem_addr_ok;
      locked_src_d = grant_src;
    end

    id_d = id_q;
    if (push) begin
      id_d[wptr_q] = grant_src;
    end
    wptr_d = wptr_q + PW'(push);
    rptr_d = rptr_q + PW'(pop);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_q       <= 1'b0;
      locked_src_q <= SRC_INST;
      cnt_q        <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      id_q         <= '0;
    end else begin
      lock_q       <= lock_d;
      locked_src_q <= locked_src_d;
      cnt_q        <= cnt_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      id_q         <= id_d;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: reset, single fetch, contention, lock, full, interleaved, mid-run reset.
module tb_sram_like_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_sram_req;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  sram_like_arbiter #(.OUT_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_sram_req  = 1'b0; inst_sram_size = 2'd2; inst_sram_addr = 32'h0;
    data_sram_req  = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd2;
    data_sram_wstrb = 4'h0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b0;
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0000;
    data_sram_req = 1'b1; data_sram_addr = 32'h8000_0000;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    total++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b00) begin bad++; $display("FAIL reset_addr_ok got=%b exp=00", {inst_sram_addr_ok, data_sram_addr_ok}); end
    total++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin bad++; $display("FAIL reset_data_ok got=%b exp=00", {inst_sram_data_ok, data_sram_data_ok}); end
    total++; if (inst_sram_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", inst_sram_rdata); end
    idle();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0000;
    #1;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h1C00_0000) begin bad++; $display("FAIL fetch_present got=%b/%h exp=1/1c000000", mem_req, mem_addr); end
    total++; if (mem_wstrb !== 4'h0 || mem_wr !== 1'b0) begin bad++; $display("FAIL fetch_wstrb got=%h/%b exp=0/0", mem_wstrb, mem_wr); end
    total++; if (inst_sram_addr_ok !== 1'b0) begin bad++; $display("FAIL fetch_early_addr_ok got=%b exp=0", inst_sram_addr_ok); end
    tick();
    mem_addr_ok = 1'b1;
    #1;
    total++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b10) begin bad++; $display("FAIL fetch_addr_ok got=%b exp=10", {inst_sram_addr_ok, data_sram_addr_ok}); end
    tick();
    idle();
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'h0280_0000;
    #1;
    total++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b10) begin bad++; $display("FAIL fetch_data_ok got=%b exp=10", {inst_sram_data_ok, data_sram_data_ok}); end
    total++; if (inst_sram_rdata !== 32'h0280_0000) begin bad++; $display("FAIL fetch_rdata got=%h exp=02800000", inst_sram_rdata); end
    tick();
    idle();
    #1;
    total++; if (inst_sram_data_ok !== 1'b0) begin bad++; $display("FAIL fetch_single_pulse got=%b exp=0", inst_sram_data_ok); end
    tick();
  endtask

  task automatic test_contention();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0040;
    data_sram_req = 1'b1; data_sram_addr = 32'h8000_0010;
    mem_addr_ok = 1'b1;
    #1;
    total++; if (mem_addr !== 32'h8000_0010 || {inst_sram_addr_ok, data_sram_addr_ok} !== 2'b01) begin bad++; $display("FAIL cont_first got=%h/%b exp=80000010/01", mem_addr, {inst_sram_addr_ok, data_sram_addr_ok}); end
    tick();
    data_sram_req = 1'b0;
    #1;
    total++; if (mem_addr !== 32'h1C00_0040 || {inst_sram_addr_ok, data_sram_addr_ok} !== 2'b10) begin bad++; $display("FAIL cont_second got=%h/%b exp=1c000040/10", mem_addr, {inst_sram_addr_ok, data_sram_addr_ok}); end
    tick();
    idle();
    mem_data_ok = 1'b1; mem_rdata = 32'hAAAA_0001;
    #1;
    total++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b01) begin bad++; $display("FAIL cont_ret1 got=%b exp=01", {inst_sram_data_ok, data_sram_data_ok}); end
    tick();
    mem_rdata = 32'hAAAA_0002;
    #1;
    total++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b10) begin bad++; $display("FAIL cont_ret2 got=%b exp=10", {inst_sram_data_ok, data_sram_data_ok}); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_lock();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0100;
    #1;
    total++; if (mem_addr !== 32'h1C00_0100) begin bad++; $display("FAIL lock_c1 got=%h exp=1c000100", mem_addr); end
    tick();
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h8000_0200;
    data_sram_wstrb = 4'hF; data_sram_wdata = 32'h1234_5678;
    for (int c = 2; c <= 3; c++) begin
      #1;
      total++; if (mem_addr !== 32'h1C00_0100 || data_sram_addr_ok !== 1'b0) begin bad++; $display("FAIL lock_hold_c%0d got=%h/%b exp=1c000100/0", c, mem_addr, data_sram_addr_ok); end
      tick();
    end
    mem_addr_ok = 1'b1;
    #1;
    total++; if (mem_addr !== 32'h1C00_0100 || inst_sram_addr_ok !== 1'b1) begin bad++; $display("FAIL lock_accept got=%h/%b exp=1c000100/1", mem_addr, inst_sram_addr_ok); end
    tick();
    inst_sram_req = 1'b0;
    #1;
    total++; if (mem_addr !== 32'h8000_0200 || data_sram_addr_ok !== 1'b1) begin bad++; $display("FAIL lock_data_after got=%h/%b exp=80000200/1", mem_addr, data_sram_addr_ok); end
    total++; if (mem_wr !== 1'b1 || mem_wstrb !== 4'hF || mem_wdata !== 32'h1234_5678) begin bad++; $display("FAIL lock_write_fields got=%b/%h/%h exp=1/f/12345678", mem_wr, mem_wstrb, mem_wdata); end
    tick();
    idle();
    mem_data_ok = 1'b1;
    #1;
    total++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b10) begin bad++; $display("FAIL lock_ret1 got=%b exp=10", {inst_sram_data_ok, data_sram_data_ok}); end
    tick();
    #1;
    total++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b01) begin bad++; $display("FAIL lock_ret2 got=%b exp=01", {inst_sram_data_ok, data_sram_data_ok}); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_full();
    mem_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_2000 + 32'(i * 4);
      #1;
      total++; if (inst_sram_addr_ok !== 1'b1) begin bad++; $display("FAIL full_fill%0d got=%b exp=1", i, inst_sram_addr_ok); end
      tick();
    end
    inst_sram_addr = 32'h1C00_2010;
    #1;
    total++; if (mem_req !== 1'b0 || inst_sram_addr_ok !== 1'b0) begin bad++; $display("FAIL full_block got=%b/%b exp=0/0", mem_req, inst_sram_addr_ok); end
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'h0000_0011;
    #1;
    total++; if (inst_sram_data_ok !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL full_pop_no_push got=%b/%b exp=1/0", inst_sram_data_ok, mem_req); end
    tick();
    mem_data_ok = 1'b0;
    #1;
    total++; if (mem_req !== 1'b1 || inst_sram_addr_ok !== 1'b1) begin bad++; $display("FAIL full_push_next got=%b/%b exp=1/1", mem_req, inst_sram_addr_ok); end
    tick();
    idle();
    mem_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (inst_sram_data_ok !== 1'b1) begin bad++; $display("FAIL full_drain%0d got=%b exp=1", i, inst_sram_data_ok); end
      tick();
    end
    #1;
    total++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin bad++; $display("FAIL full_spurious got=%b exp=00", {inst_sram_data_ok, data_sram_data_ok}); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_interleaved();
    logic [31:0] iexp[$];
    logic [31:0] dexp[$];
    logic [31:0] bq[$];
    int ii, di, irx, drx;
    logic dok;
    ii = 0; di = 0; irx = 0; drx = 0;
    for (int cyc = 0; cyc < 400 && (irx < 4 || drx < 4); cyc++) begin
      inst_sram_req  = (ii < 4);
      inst_sram_addr = 32'h1C00_3000 + 32'(ii * 4);
      data_sram_req  = (di < 4);
      data_sram_addr = 32'h8000_3000 + 32'(di * 4);
      mem_addr_ok    = ($urandom_range(0, 1) == 1);
      dok            = (bq.size() > 0) && ($urandom_range(0, 2) != 0);
      mem_data_ok    = dok;
      mem_rdata      = dok ? ~bq[0] : 32'h0;
      #1;
      if (dok) begin
        total++; if ((inst_sram_data_ok ^ data_sram_data_ok) !== 1'b1) begin bad++; $display("FAIL inter_one_ok cyc=%0d got=%b exp=one-hot", cyc, {inst_sram_data_ok, data_sram_data_ok}); end
        void'(bq.pop_front());
      end
      if (inst_sram_data_ok) begin
        total++;
        if (iexp.size() == 0) begin bad++; $display("FAIL inter_inst_extra cyc=%0d got=pulse exp=none", cyc); end
        else begin
          if (inst_sram_rdata !== ~iexp[0]) begin bad++; $display("FAIL inter_inst_data cyc=%0d got=%h exp=%h", cyc, inst_sram_rdata, ~iexp[0]); end
          void'(iexp.pop_front());
        end
        irx++;
      end
      if (data_sram_data_ok) begin
        total++;
        if (dexp.size() == 0) begin bad++; $display("FAIL inter_data_extra cyc=%0d got=pulse exp=none", cyc); end
        else begin
          if (data_sram_rdata !== ~dexp[0]) begin bad++; $display("FAIL inter_data_data cyc=%0d got=%h exp=%h", cyc, data_sram_rdata, ~dexp[0]); end
          void'(dexp.pop_front());
        end
        drx++;
      end
      if (mem_req && mem_addr_ok) bq.push_back(mem_addr);
      if (inst_sram_addr_ok) begin iexp.push_back(inst_sram_addr); ii++; end
      if (data_sram_addr_ok) begin dexp.push_back(data_sram_addr); di++; end
      tick();
    end
    idle();
    total++; if (irx !== 4 || drx !== 4) begin bad++; $display("FAIL inter_counts got=%0d/%0d exp=4/4", irx, drx); end
    total++; if (bq.size() !== 0) begin bad++; $display("FAIL inter_bridge_left got=%0d exp=0", bq.size()); end
    mem_data_ok = 1'b1;
    #1;
    total++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin bad++; $display("FAIL inter_drained got=%b exp=00", {inst_sram_data_ok, data_sram_data_ok}); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_mid_reset();
    mem_addr_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_4000 + 32'(i * 4);
      tick();
    end
    resetn = 1'b0;
    #1;
    total++; if (inst_sram_addr_ok !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL mrst_gated got=%b/%b exp=0/0", inst_sram_addr_ok, mem_req); end
    tick();
    idle();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_data_ok = 1'b1; mem_rdata = 32'hBAD0_0000 + 32'(i);
      #1;
      total++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin bad++; $display("FAIL mrst_stray%0d got=%b exp=00", i, {inst_sram_data_ok, data_sram_data_ok}); end
      tick();
    end
    idle();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_5000; mem_addr_ok = 1'b1;
    #1;
    total++; if (inst_sram_addr_ok !== 1'b1 || mem_addr !== 32'h1C00_5000) begin bad++; $display("FAIL mrst_new_req got=%b/%h exp=1/1c005000", inst_sram_addr_ok, mem_addr); end
    tick();
    idle();
    mem_data_ok = 1'b1; mem_rdata = 32'h0000_ABCD;
    #1;
    total++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h0000_ABCD) begin bad++; $display("FAIL mrst_new_ret got=%b/%h exp=1/0000abcd", inst_sram_data_ok, inst_sram_rdata); end
    tick();
    idle();
    tick();
  endtask

  initial begin
    idle();
    resetn = 1'b0;
    test_reset();
    test_single_fetch();
    test_contention();
    test_lock();
    test_full();
    test_interleaved();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
